// File: rtl/huffman_node_sorter_pkg.sv
// Shared definitions for the Huffman node sorter.
// Holds the default field widths, the node/pair counts of the 7-record
// odd-even transposition network, the FSM state type and a phase helper.
package huffman_node_sorter_pkg;

  localparam int DEF_ID_W     = 4;
  localparam int DEF_WEIGHT_W = 8;
  localparam int NUM_NODES    = 7;
  localparam int NUM_PAIRS    = 3;

  // Index of the final compare-exchange phase (7 phases: 0..6).
  localparam logic [2:0] LAST_PHASE = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } sort_state_e;

  // Odd phases compare pairs (2,3)(4,5)(6,7); even phases (1,2)(3,4)(5,6).
  function automatic logic is_odd_phase(input logic [2:0] phase);
    return phase[0];
  endfunction

endpackage

// File: rtl/huffman_node_sorter_node_cmp_swap.sv
// Combinational compare-exchange element for two node records.
// Ports:
//   node_a, node_b : records at the lower / higher position of the pair
//   lo_node        : record with the smaller weight (node_a on a tie)
//   hi_node        : the other record
//   swapped        : 1 when the records were exchanged
// Only the weight field takes part in the compare; id and flag travel with
// their record. Ties keep the original order, which makes the sort stable.
module huffman_node_sorter_node_cmp_swap #(
  parameter int NODE_W   = 13,
  parameter int WEIGHT_W = 8
) (
  input  logic [NODE_W-1:0] node_a,
  input  logic [NODE_W-1:0] node_b,
  output logic [NODE_W-1:0] lo_node,
  output logic [NODE_W-1:0] hi_node,
  output logic              swapped
);

  // Strict unsigned weight compare selects the exchange.
  always_comb begin
    swapped = (node_a[WEIGHT_W-1:0] > node_b[WEIGHT_W-1:0]);
    if (swapped) begin
      lo_node = node_b;
      hi_node = node_a;
    end else begin
      lo_node = node_a;
      hi_node = node_b;
    end
  end

endmodule

// File: rtl/huffman_node_sorter.sv
// Huffman node sorter: orders 7 node records by ascending weight with an
// odd-even transposition network, one compare-exchange phase per clock.
// Record layout: {id[ID_W-1:0], internal_flag, weight[WEIGHT_W-1:0]}.
// Ports:
//   CLK                 : clock, rising edge
//   nRST                : synchronous reset, active low
//   load                : start strobe, accepted only while idle
//   in_node_1..7        : unsorted records, captured on an accepted load
//   busy                : high while sorting and in the done cycle
//   done                : one-cycle pulse when the sorted set is first valid
//   sorted_valid        : info_node_* hold a sorted set
//   info_node_1..7      : node records, info_node_1 has the smallest weight
// Optional build macro HUFF_SORT_EARLY_EXIT_EN: finish as soon as two
// consecutive phases make no exchange (minimum two phases).
module huffman_node_sorter
  import huffman_node_sorter_pkg::*;
#(
  parameter  int ID_W     = DEF_ID_W,
  parameter  int WEIGHT_W = DEF_WEIGHT_W,
  localparam int NODE_W   = ID_W + 1 + WEIGHT_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic [NODE_W-1:0] in_node_1,
  input  logic [NODE_W-1:0] in_node_2,
  input  logic [NODE_W-1:0] in_node_3,
  input  logic [NODE_W-1:0] in_node_4,
  input  logic [NODE_W-1:0] in_node_5,
  input  logic [NODE_W-1:0] in_node_6,
  input  logic [NODE_W-1:0] in_node_7,
  output logic              busy,
  output logic              done,
  output logic              sorted_valid,
  output logic [NODE_W-1:0] info_node_1,
  output logic [NODE_W-1:0] info_node_2,
  output logic [NODE_W-1:0] info_node_3,
  output logic [NODE_W-1:0] info_node_4,
  output logic [NODE_W-1:0] info_node_5,
  output logic [NODE_W-1:0] info_node_6,
  output logic [NODE_W-1:0] info_node_7
);

  sort_state_e       state_r, state_nxt_s;
  logic [2:0]        phase_r, phase_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic [NODE_W-1:0] nodes_r       [NUM_NODES];
  logic [NODE_W-1:0] nodes_nxt_s   [NUM_NODES];
  logic [NODE_W-1:0] in_nodes_s    [NUM_NODES];
  logic [NODE_W-1:0] even_nodes_s  [NUM_NODES];
  logic [NODE_W-1:0] odd_nodes_s   [NUM_NODES];
  logic [NODE_W-1:0] phase_nodes_s [NUM_NODES];
  logic [NODE_W-1:0] pair_a_s      [NUM_PAIRS];
  logic [NODE_W-1:0] pair_b_s      [NUM_PAIRS];
  logic [NODE_W-1:0] pair_lo_s     [NUM_PAIRS];
  logic [NODE_W-1:0] pair_hi_s     [NUM_PAIRS];
  logic [NUM_PAIRS-1:0] swap_s;
  logic              odd_s;
  logic              any_swap_s;
  logic              sort_exit_s;

  assign in_nodes_s[0] = in_node_1;
  assign in_nodes_s[1] = in_node_2;
  assign in_nodes_s[2] = in_node_3;
  assign in_nodes_s[3] = in_node_4;
  assign in_nodes_s[4] = in_node_5;
  assign in_nodes_s[5] = in_node_6;
  assign in_nodes_s[6] = in_node_7;

  assign odd_s      = is_odd_phase(phase_r);
  assign any_swap_s = |swap_s;

  // Three shared compare-exchange elements; the pair feeding each one is
  // chosen by phase parity, and both candidate results are assembled.
  for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pair
    assign pair_a_s[g] = odd_s ? nodes_r[2*g+1] : nodes_r[2*g];
    assign pair_b_s[g] = odd_s ? nodes_r[2*g+2] : nodes_r[2*g+1];

    huffman_node_sorter_node_cmp_swap #(
      .NODE_W   (NODE_W),
      .WEIGHT_W (WEIGHT_W)
    ) u_cmp (
      .node_a  (pair_a_s[g]),
      .node_b  (pair_b_s[g]),
      .lo_node (pair_lo_s[g]),
      .hi_node (pair_hi_s[g]),
      .swapped (swap_s[g])
    );

    assign even_nodes_s[2*g]   = pair_lo_s[g];
    assign even_nodes_s[2*g+1] = pair_hi_s[g];
    assign odd_nodes_s[2*g+1]  = pair_lo_s[g];
    assign odd_nodes_s[2*g+2]  = pair_hi_s[g];
  end

  // Unpaired end records pass straight through their phase.
  assign even_nodes_s[NUM_NODES-1] = nodes_r[NUM_NODES-1];
  assign odd_nodes_s[0]            = nodes_r[0];

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_sel
    assign phase_nodes_s[n] = odd_s ? odd_nodes_s[n] : even_nodes_s[n];
  end

`ifdef HUFF_SORT_EARLY_EXIT_EN
  logic noswap_prev_r;

  // Remembers that the previous phase of this sort made no exchange.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      noswap_prev_r <= 1'b0;
    end else if (state_r == ST_SORT) begin
      noswap_prev_r <= ~any_swap_s;
    end else begin
      noswap_prev_r <= 1'b0;
    end
  end

  assign sort_exit_s = (phase_r == LAST_PHASE) || (noswap_prev_r && !any_swap_s);
`else
  logic unused_swap_s;
  assign unused_swap_s = any_swap_s;
  assign sort_exit_s   = (phase_r == LAST_PHASE);
`endif

  // Next-state and next-output decode for the IDLE/SORT/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    valid_nxt_s = valid_r;
    nodes_nxt_s = nodes_r;
    case (state_r)
      ST_IDLE: begin
        if (load) begin
          state_nxt_s = ST_SORT;
          phase_nxt_s = 3'd0;
          busy_nxt_s  = 1'b1;
          valid_nxt_s = 1'b0;
          nodes_nxt_s = in_nodes_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SORT: begin
        nodes_nxt_s = phase_nodes_s;
        phase_nxt_s = phase_r + 3'd1;
        if (sort_exit_s) begin
          state_nxt_s = ST_DONE;
          done_nxt_s  = 1'b1;
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_SORT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        phase_nxt_s = 3'd0;
        busy_nxt_s  = 1'b0;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, phase, status and node registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
      phase_r <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) begin
        nodes_r[i] <= {NODE_W{1'b0}};
      end
    end else begin
      state_r <= state_nxt_s;
      phase_r <= phase_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      valid_r <= valid_nxt_s;
      nodes_r <= nodes_nxt_s;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign sorted_valid = valid_r;
  assign info_node_1  = nodes_r[0];
  assign info_node_2  = nodes_r[1];
  assign info_node_3  = nodes_r[2];
  assign info_node_4  = nodes_r[3];
  assign info_node_5  = nodes_r[4];
  assign info_node_6  = nodes_r[5];
  assign info_node_7  = nodes_r[6];

endmodule

// File: tb/tb_huffman_node_sorter.sv
// Self-checking bench for huffman_node_sorter. Stimulus pushes the expected
// sorted set and latency into a scoreboard queue; a monitor pops and
// compares whenever done is seen. Cycle numbering: the edge that accepts
// load is cycle T; an output sampled after edge k belongs to cycle k+1.
module tb_huffman_node_sorter;

  localparam int NW = 13;
  localparam int VW = 7 * NW;
`ifdef HUFF_SORT_EARLY_EXIT_EN
  localparam int LAT_SORTED = 3;
`else
  localparam int LAT_SORTED = 8;
`endif
  localparam int LAT_FULL = 8;

  typedef struct {
    logic [VW-1:0] nodes;
    int            lat;
    int            load_cyc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          load = 1'b0;
  logic [VW-1:0] in_vec = '0;
  logic [VW-1:0] out_vec;
  logic          busy, done, sorted_valid;
  logic [NW-1:0] info_node_1, info_node_2, info_node_3, info_node_4;
  logic [NW-1:0] info_node_5, info_node_6, info_node_7;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t mon_e;

  logic [VW-1:0] t1_in, t1_exp, t2_in, t3_in, t4_in, t4_exp;

  huffman_node_sorter dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .load         (load),
    .in_node_1    (in_vec[0*NW +: NW]),
    .in_node_2    (in_vec[1*NW +: NW]),
    .in_node_3    (in_vec[2*NW +: NW]),
    .in_node_4    (in_vec[3*NW +: NW]),
    .in_node_5    (in_vec[4*NW +: NW]),
    .in_node_6    (in_vec[5*NW +: NW]),
    .in_node_7    (in_vec[6*NW +: NW]),
    .busy         (busy),
    .done         (done),
    .sorted_valid (sorted_valid),
    .info_node_1  (info_node_1),
    .info_node_2  (info_node_2),
    .info_node_3  (info_node_3),
    .info_node_4  (info_node_4),
    .info_node_5  (info_node_5),
    .info_node_6  (info_node_6),
    .info_node_7  (info_node_7)
  );

  assign out_vec = {info_node_7, info_node_6, info_node_5, info_node_4,
                    info_node_3, info_node_2, info_node_1};

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [VW-1:0] pk(input logic [NW-1:0] a, b, c, d, e, f, g);
    return {g, f, e, d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (nRST && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        for (int i = 0; i < 7; i++)
          chk($sformatf("node%0d", i + 1), VW'(out_vec[i*NW +: NW]), VW'(mon_e.nodes[i*NW +: NW]));
        chk("done_latency", VW'(cyc + 1 - mon_e.load_cyc), VW'(mon_e.lat));
        chk("valid_at_done", VW'(sorted_valid), VW'(1));
        chk("busy_at_done", VW'(busy), VW'(1));
      end
    end
  end

  task automatic issue(input logic [VW-1:0] nodes, input logic [VW-1:0] exp_nodes, input int lat);
    exp_t e;
    @(negedge CLK);
    in_vec = nodes;
    load   = 1'b1;
    e.nodes = exp_nodes;
    e.lat = lat;
    e.load_cyc = cyc + 1;
    q.push_back(e);
    @(negedge CLK);
    load = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [VW-1:0] exp_nodes);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=pending required=done", name);
      q.delete();
    end
    @(negedge CLK);
    chk({name, "_done_pulse"}, VW'(done), VW'(0));
    chk({name, "_busy_idle"}, VW'(busy), VW'(0));
    chk({name, "_valid_hold"}, VW'(sorted_valid), VW'(1));
    repeat (2) @(negedge CLK);
    chk({name, "_nodes_hold"}, out_vec, exp_nodes);
  endtask

  initial begin
    // Test 1 vectors: reversed weights, ids 6..0
    t1_in  = pk({4'd6, 1'b0, 8'h77}, {4'd5, 1'b0, 8'h44}, {4'd4, 1'b0, 8'h3D},
                {4'd3, 1'b0, 8'h2B}, {4'd2, 1'b0, 8'h22}, {4'd1, 1'b0, 8'h1C},
                {4'd0, 1'b0, 8'h1A});
    t1_exp = pk({4'd0, 1'b0, 8'h1A}, {4'd1, 1'b0, 8'h1C}, {4'd2, 1'b0, 8'h22},
                {4'd3, 1'b0, 8'h2B}, {4'd4, 1'b0, 8'h3D}, {4'd5, 1'b0, 8'h44},
                {4'd6, 1'b0, 8'h77});
    // Test 2: already sorted, mixed ids and flags
    t2_in  = pk(13'b0000_0_0001_1010, {4'd3, 1'b1, 8'h1C}, {4'd5, 1'b0, 8'h22},
                {4'd7, 1'b1, 8'h2B}, {4'd9, 1'b0, 8'h3D}, {4'd11, 1'b1, 8'h44},
                13'b1111_1_0111_0111);
    // Test 3: all weights equal, ids 1..7, alternating flags
    t3_in  = pk({4'd1, 1'b1, 8'h40}, {4'd2, 1'b0, 8'h40}, {4'd3, 1'b1, 8'h40},
                {4'd4, 1'b0, 8'h40}, {4'd5, 1'b1, 8'h40}, {4'd6, 1'b0, 8'h40},
                {4'd7, 1'b1, 8'h40});
    // Test 4: boundary weights, ids 1..7
    t4_in  = pk({4'd1, 1'b0, 8'hFF}, {4'd2, 1'b0, 8'h00}, {4'd3, 1'b0, 8'hFF},
                {4'd4, 1'b0, 8'h00}, {4'd5, 1'b0, 8'h80}, {4'd6, 1'b0, 8'h7F},
                {4'd7, 1'b0, 8'h01});
    t4_exp = pk({4'd2, 1'b0, 8'h00}, {4'd4, 1'b0, 8'h00}, {4'd7, 1'b0, 8'h01},
                {4'd6, 1'b0, 8'h7F}, {4'd5, 1'b0, 8'h80}, {4'd1, 1'b0, 8'hFF},
                {4'd3, 1'b0, 8'hFF});

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_done", VW'(done), VW'(0));
    chk("rst_valid", VW'(sorted_valid), VW'(0));
    chk("rst_nodes", out_vec, '0);
    nRST = 1'b1;

    issue(t1_in, t1_exp, LAT_FULL);
    wait_done("reverse", t1_exp);

    issue(t2_in, t2_in, LAT_SORTED);
    wait_done("sorted", t2_in);

    issue(t3_in, t3_in, LAT_SORTED);
    wait_done("stable", t3_in);

    issue(t4_in, t4_exp, LAT_FULL);
    wait_done("boundary", t4_exp);

    // Test 5: load pulse at T+3 while sorting must be ignored
    begin
      exp_t e;
      @(negedge CLK);
      in_vec = t1_in;
      load = 1'b1;
      e.nodes = t1_exp;
      e.lat = LAT_FULL;
      e.load_cyc = cyc + 1;
      q.push_back(e);
      for (int k = 0; k < 8; k++) begin
        @(negedge CLK);
        load = (k == 2) ? 1'b1 : 1'b0;
        if (k == 2) in_vec = t4_in;
        chk($sformatf("busy_hold_c%0d", k + 1), VW'(busy), VW'(1));
      end
      wait_done("ignored_load", t1_exp);
    end

    // Test 6: reset at T+4 aborts the sort, then a fresh sort works
    issue(t1_in, t1_exp, LAT_FULL);
    repeat (2) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    q.delete();
    chk("abort_nodes", out_vec, '0);
    chk("abort_busy", VW'(busy), VW'(0));
    chk("abort_valid", VW'(sorted_valid), VW'(0));
    chk("abort_done", VW'(done), VW'(0));
    issue(t4_in, t4_exp, LAT_FULL);
    wait_done("after_reset", t4_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
